// File: rtl/fnv_pkg.sv
// fnv_pkg: shared constants and types for the FNV hash stream engine.
//   FNV32_BASIS/FNV32_PRIME, FNV64_BASIS/FNV64_PRIME : standard FNV offset basis and prime.
//   fnv_state_e : engine FSM states (ABSORB, DONE).
//   fnv_basis()/fnv_prime() : pick the 64-bit-wide constant for a digest width.
package fnv_pkg;

   localparam logic [31:0] FNV32_BASIS = 32'h811C_9DC5;
   localparam logic [31:0] FNV32_PRIME = 32'h0100_0193;
   localparam logic [63:0] FNV64_BASIS = 64'hCBF2_9CE4_8422_2325;
   localparam logic [63:0] FNV64_PRIME = 64'h0000_0100_0000_01B3;

   typedef enum logic {
      ABSORB = 1'b0,
      DONE   = 1'b1
   } fnv_state_e;

   // Constants are returned zero-extended to 64 bits; callers truncate to HASH_W.
   function automatic logic [63:0] fnv_basis(input int width);
      return (width == 64) ? FNV64_BASIS : {32'h0, FNV32_BASIS};
   endfunction

   function automatic logic [63:0] fnv_prime(input int width);
      return (width == 64) ? FNV64_PRIME : {32'h0, FNV32_PRIME};
   endfunction

endpackage

// File: rtl/fnv_round.sv
// fnv_round: combinational single-octet FNV step.
//   VARIANT=0 (FNV-1a): hash_next = (hash ^ octet) * PRIME
//   VARIANT=1 (FNV-1) : hash_next = (hash * PRIME) ^ octet
// The product is kept modulo 2^HASH_W; the octet is zero-extended for the xor.
// Ports:
//   hash      in  HASH_W  current hash state
//   octet     in  8       message byte
//   hash_next out HASH_W  hash after absorbing octet
module fnv_round
   import fnv_pkg::*;
#(
   parameter int HASH_W  = 32,
   parameter int VARIANT = 0
) (
   input  logic [HASH_W-1:0] hash,
   input  logic [7:0]        octet,
   output logic [HASH_W-1:0] hash_next
);

   localparam logic [63:0]       PRIME_64 = fnv_prime(HASH_W);
   localparam logic [HASH_W-1:0] PRIME    = PRIME_64[HASH_W-1:0];

   logic [HASH_W-1:0] octet_ext;
   assign octet_ext = {{(HASH_W-8){1'b0}}, octet};

   // Assignment context is HASH_W wide, so the multiply truncates to the modulus.
   generate
      if (VARIANT == 0) begin : g_fnv1a
         assign hash_next = (hash ^ octet_ext) * PRIME;
      end else if (VARIANT == 1) begin : g_fnv1
         assign hash_next = (hash * PRIME) ^ octet_ext;
      end else begin : g_bad_variant
         $error("fnv_round: VARIANT must be 0 or 1");
         assign hash_next = hash;
      end
   endgenerate

endmodule

// File: rtl/fnv_hash_stream.sv
// fnv_hash_stream: byte-streaming FNV-1/FNV-1a hash engine, 32- or 64-bit digest.
// Absorbs one octet per clock over in_valid/in_ready until in_last, then presents
// the digest on out_valid/out_ready and re-seeds to the basis on the handshake.
// Optional feature macro: FNV_BYTE_COUNT_EN adds a saturating byte counter and
// the out_count port; the hash path is identical either way.
// Ports:
//   clk        in   1        clock
//   reset      in   1        synchronous, active-high
//   in_valid   in   1        in_data/in_last valid
//   in_ready   out  1        byte accepted this cycle (ABSORB)
//   in_data    in   8        message octet
//   in_last    in   1        octet ends the message
//   out_valid  out  1        out_hash holds a finished digest (DONE)
//   out_ready  in   1        consumer takes the digest
//   out_hash   out  HASH_W   digest (register output)
//   out_count  out  COUNT_W  message byte count (FNV_BYTE_COUNT_EN only)
module fnv_hash_stream
   import fnv_pkg::*;
#(
   parameter int HASH_W  = 32,
   parameter int VARIANT = 0,
   parameter int COUNT_W = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [7:0]        in_data,
   input  logic              in_last,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [HASH_W-1:0] out_hash
`ifdef FNV_BYTE_COUNT_EN
   ,
   output logic [COUNT_W-1:0] out_count
`endif
);

   generate
      if (HASH_W != 32 && HASH_W != 64) begin : g_bad_width
         $error("fnv_hash_stream: HASH_W must be 32 or 64");
      end
      if (COUNT_W < 1) begin : g_bad_count_w
         $error("fnv_hash_stream: COUNT_W must be at least 1");
      end
   endgenerate

   localparam logic [63:0]       BASIS_64 = fnv_basis(HASH_W);
   localparam logic [HASH_W-1:0] BASIS    = BASIS_64[HASH_W-1:0];

   fnv_state_e        state;
   logic [HASH_W-1:0] hash_q;
   logic [HASH_W-1:0] hash_next;
   logic              in_ready_q;
   logic              out_valid_q;

   fnv_round #(
      .HASH_W (HASH_W),
      .VARIANT(VARIANT)
   ) u_round (
      .hash     (hash_q),
      .octet    (in_data),
      .hash_next(hash_next)
   );

   // Handshake flags are registered copies of the state. They are masked while
   // reset is asserted so neither side sees a handshake in the reset cycle,
   // even before the first edge has cleared the registers.
   assign in_ready  = in_ready_q & ~reset;
   assign out_valid = out_valid_q & ~reset;
   assign out_hash  = hash_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= ABSORB;
         hash_q      <= BASIS;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
      end else begin
         case (state)
            ABSORB: begin
               if (in_valid && in_ready_q) begin
                  hash_q <= hash_next;
                  if (in_last) begin
                     state       <= DONE;
                     in_ready_q  <= 1'b0;
                     out_valid_q <= 1'b1;
                  end
               end
            end
            DONE: begin
               // Digest leaves and the engine re-seeds on the same edge.
               if (out_ready) begin
                  state       <= ABSORB;
                  hash_q      <= BASIS;
                  in_ready_q  <= 1'b1;
                  out_valid_q <= 1'b0;
               end
            end
            default: begin
               state       <= ABSORB;
               hash_q      <= BASIS;
               in_ready_q  <= 1'b1;
               out_valid_q <= 1'b0;
            end
         endcase
      end
   end

`ifdef FNV_BYTE_COUNT_EN
   logic [COUNT_W-1:0] count_q;

   // Counts accepts in ABSORB, saturating at all-ones; held through DONE and
   // cleared together with the re-seed.
   always_ff @(posedge clk) begin
      if (reset) begin
         count_q <= '0;
      end else if (state == ABSORB) begin
         if (in_valid && in_ready_q && (count_q != {COUNT_W{1'b1}}))
            count_q <= count_q + 1'b1;
      end else if (out_ready) begin
         count_q <= '0;
      end
   end

   assign out_count = count_q;
`endif

endmodule

// File: tb/tb_fnv_hash_stream.sv
// tb_fnv_hash_stream: four engines (32/64-bit x FNV-1a/FNV-1) share one stimulus
// stream and run in lockstep. A driver pushes expected digests into a scoreboard
// queue as it issues each message; a negedge monitor pops and compares on every
// digest handshake. Expected digests come from the published FNV constants or
// from a plain-arithmetic reference model.
module tb_fnv_hash_stream;

   logic       clk = 1'b0;
   logic       reset;
   logic       in_valid;
   logic [7:0] in_data;
   logic       in_last;
   logic       out_ready = 1'b0;
   logic [3:0] rdy;
   logic [3:0] vld;
   logic [31:0] h0, h1;
   logic [63:0] h2, h3;
`ifdef FNV_BYTE_COUNT_EN
   logic [15:0] c0, c1, c2, c3;
`endif

   always #5 clk = ~clk;

   fnv_hash_stream #(.HASH_W(32), .VARIANT(0), .COUNT_W(16)) u_32a (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(rdy[0]), .in_data(in_data),
      .in_last(in_last), .out_valid(vld[0]), .out_ready(out_ready), .out_hash(h0)
`ifdef FNV_BYTE_COUNT_EN
      , .out_count(c0)
`endif
   );
   fnv_hash_stream #(.HASH_W(32), .VARIANT(1), .COUNT_W(16)) u_32b (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(rdy[1]), .in_data(in_data),
      .in_last(in_last), .out_valid(vld[1]), .out_ready(out_ready), .out_hash(h1)
`ifdef FNV_BYTE_COUNT_EN
      , .out_count(c1)
`endif
   );
   fnv_hash_stream #(.HASH_W(64), .VARIANT(0), .COUNT_W(16)) u_64a (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(rdy[2]), .in_data(in_data),
      .in_last(in_last), .out_valid(vld[2]), .out_ready(out_ready), .out_hash(h2)
`ifdef FNV_BYTE_COUNT_EN
      , .out_count(c2)
`endif
   );
   fnv_hash_stream #(.HASH_W(64), .VARIANT(1), .COUNT_W(16)) u_64b (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(rdy[3]), .in_data(in_data),
      .in_last(in_last), .out_valid(vld[3]), .out_ready(out_ready), .out_hash(h3)
`ifdef FNV_BYTE_COUNT_EN
      , .out_count(c3)
`endif
   );

   typedef struct packed {
      logic [3:0][63:0] h;   // 32a, 32-1, 64a, 64-1
      logic [31:0]      cnt;
   } exp_t;

   exp_t sbq[$];
   exp_t mon_e;
   int   checks = 0;
   int   failures = 0;
   int   cyc = 0;
   int   exp_vld_cyc = -1;
   bit   or_force = 1'b1;
   bit   or_val = 1'b1;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Reference model: straight from the FNV definition, 64-bit arithmetic masked.
   function automatic logic [63:0] ref_hash(input logic [7:0] m[$], input int w, input int v);
      longint unsigned h, p, mask;
      if (w == 32) begin
         h = 64'h811C9DC5; p = 64'h01000193; mask = 64'hFFFF_FFFF;
      end else begin
         h = 64'hCBF29CE484222325; p = 64'h100000001B3; mask = '1;
      end
      foreach (m[i]) begin
         if (v == 0) h = ((h ^ {56'h0, m[i]}) * p) & mask;
         else        h = ((h * p) & mask) ^ {56'h0, m[i]};
      end
      return h;
   endfunction

   function automatic exp_t mk_exp(input logic [7:0] m[$]);
      exp_t e;
      e.h[0] = ref_hash(m, 32, 0);
      e.h[1] = ref_hash(m, 32, 1);
      e.h[2] = ref_hash(m, 64, 0);
      e.h[3] = ref_hash(m, 64, 1);
      e.cnt  = (m.size() > 65535) ? 65535 : m.size();
      return e;
   endfunction

   always @(posedge clk) cyc <= cyc + 1;

   // out_ready changes just after each edge: held or random.
   initial forever begin
      @(posedge clk); #1;
      out_ready = or_force ? or_val : ($urandom_range(0, 3) != 0);
   end

   // Monitor / scoreboard.
   always @(negedge clk) begin
      if (reset) begin
         chk("reset_out_valid", {60'h0, vld}, 64'h0);
         chk("reset_in_ready", {60'h0, rdy}, 64'h0);
      end else begin
         if (cyc == exp_vld_cyc) begin
            chk("latency_out_valid", {60'h0, vld}, 64'hF);
            chk("done_in_ready", {60'h0, rdy}, 64'h0);
         end
         if (vld[0] && out_ready) begin
            if (sbq.size() == 0) begin
               checks++; failures++;
               $display("FAIL unexpected_digest actual=%h required=none", h0);
            end else begin
               mon_e = sbq.pop_front();
               chk("lockstep_valid", {60'h0, vld}, 64'hF);
               chk("hash_fnv1a_32", {32'h0, h0}, mon_e.h[0]);
               chk("hash_fnv1_32",  {32'h0, h1}, mon_e.h[1]);
               chk("hash_fnv1a_64", h2, mon_e.h[2]);
               chk("hash_fnv1_64",  h3, mon_e.h[3]);
`ifdef FNV_BYTE_COUNT_EN
               chk("count_32a", {48'h0, c0}, {32'h0, mon_e.cnt});
               chk("count_64b", {48'h0, c3}, {32'h0, mon_e.cnt});
`endif
            end
         end
      end
   end

   // Presents one byte starting just after an edge; returns after the accepting edge.
   task automatic send_byte(input logic [7:0] d, input bit last, input bit first, output int stalls);
      in_valid = 1'b1; in_data = d; in_last = last; stalls = 0;
      @(negedge clk);
      while (!rdy[0] && stalls < 200) begin
         stalls++;
         @(negedge clk);
      end
      if (stalls >= 200) begin
         checks++; failures++;
         $display("FAIL accept_timeout actual=in_ready_low required=accept_within_200");
      end else if (!first) begin
         chk("no_bubble", stalls, 0);
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
      in_last  = 1'b0;
      if (last) exp_vld_cyc = cyc;
   endtask

   task automatic send_msg(input logic [7:0] m[$], input exp_t e, input int gap_max,
                           output int first_stall);
      int st;
      sbq.push_back(e);
      first_stall = 0;
      for (int i = 0; i < m.size(); i++) begin
         send_byte(m[i], i == m.size() - 1, i == 0, st);
         if (i == 0) first_stall = st;
         if (i != m.size() - 1)
            repeat ($urandom_range(0, gap_max)) begin @(posedge clk); #1; end
      end
   endtask

   task automatic drain();
      int n = 0;
      while (sbq.size() != 0 && n < 500) begin @(posedge clk); #1; n++; end
      if (sbq.size() != 0) begin
         checks++; failures++;
         $display("FAIL drain_timeout actual=%0d_pending required=0", sbq.size());
      end
   endtask

   task automatic chk_basis(input string tag);
      chk({tag, "_basis32a"}, {32'h0, h0}, 64'h811C9DC5);
      chk({tag, "_basis32b"}, {32'h0, h1}, 64'h811C9DC5);
      chk({tag, "_basis64a"}, h2, 64'hCBF29CE484222325);
      chk({tag, "_basis64b"}, h3, 64'hCBF29CE484222325);
      chk({tag, "_in_ready"}, {60'h0, rdy}, 64'hF);
      chk({tag, "_out_valid"}, {60'h0, vld}, 64'h0);
`ifdef FNV_BYTE_COUNT_EN
      chk({tag, "_count"}, {48'h0, c0}, 64'h0);
`endif
   endtask

   initial begin
      logic [7:0] msg_a[$];
      logic [7:0] msg_fb[$];
      logic [7:0] rmsg[$];
      exp_t e_a, e_fb, e;
      int   st;
      logic [31:0] hold0, hold1;
      logic [63:0] hold2, hold3;

      msg_a  = '{8'h61};
      msg_fb = '{8'h66, 8'h6f, 8'h6f, 8'h62, 8'h61, 8'h72};
      e_a = mk_exp(msg_a);
      e_a.h[0] = 64'hE40C292C;
      e_a.h[1] = 64'h050C5D7E;
      e_a.h[2] = 64'hAF63DC4C8601EC8C;
      e_a.h[3] = 64'hAF63BD4C8601B7BE;
      e_fb = mk_exp(msg_fb);
      e_fb.h[0] = 64'hBF9CF968;
      e_fb.h[2] = 64'h85944171F73967E8;

      // Reset state.
      reset = 1'b1; in_valid = 1'b0; in_data = 8'h00; in_last = 1'b0;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      chk_basis("reset");
      @(posedge clk); #1;

      // Directed vectors, out_ready held high: back-to-back messages.
      or_force = 1'b1; or_val = 1'b1;
      send_msg(msg_a, e_a, 0, st);
      chk("first_msg_stall", st, 0);
      send_msg(msg_fb, e_fb, 0, st);
      chk("min_period_stall", st, 1);
      send_msg(msg_a, e_a, 0, st);
      chk("reseed_stall", st, 1);
      drain();

      // Backpressure: digest held 5 cycles while the next message waits.
      or_val = 1'b0;
      fork
         begin
            send_msg(msg_a, e_a, 0, st);
            send_msg(msg_fb, e_fb, 2, st);
         end
         begin
            int n = 0;
            @(negedge clk);
            while (!vld[0] && n < 100) begin n++; @(negedge clk); end
            chk("bp_reached_done", {63'h0, vld[0]}, 64'h1);
            hold0 = h0; hold1 = h1; hold2 = h2; hold3 = h3;
            repeat (5) begin
               @(negedge clk);
               chk("bp_in_ready", {60'h0, rdy}, 64'h0);
               chk("bp_out_valid", {60'h0, vld}, 64'hF);
               chk("bp_hash32a_stable", {32'h0, h0}, {32'h0, hold0});
               chk("bp_hash32b_stable", {32'h0, h1}, {32'h0, hold1});
               chk("bp_hash64a_stable", h2, hold2);
               chk("bp_hash64b_stable", h3, hold3);
            end
            or_val = 1'b1;
         end
      join
      drain();

      // Reset mid-message: "foo" is discarded.
      send_byte(8'h66, 1'b0, 1'b1, st);
      send_byte(8'h6f, 1'b0, 1'b0, st);
      send_byte(8'h6f, 1'b0, 1'b0, st);
      reset = 1'b1;
      @(posedge clk); #1 reset = 1'b0;
      @(negedge clk);
      chk_basis("midmsg");
      @(posedge clk); #1;
      send_msg(msg_a, e_a, 0, st);
      drain();

      // Reset while a digest is pending in DONE: digest is dropped.
      or_val = 1'b0;
      send_byte(8'h61, 1'b1, 1'b1, st);
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk); #1 reset = 1'b0;
      @(negedge clk);
      chk_basis("done_rst");
      or_val = 1'b1;
      @(posedge clk); #1;

      // Randomised messages, in_valid gaps and out_ready backpressure.
      or_force = 1'b0;
      for (int k = 0; k < 40; k++) begin
         rmsg.delete();
         for (int j = 0; j < int'($urandom_range(1, 12)); j++)
            rmsg.push_back(8'($urandom_range(0, 255)));
         e = mk_exp(rmsg);
         send_msg(rmsg, e, 2, st);
      end
      drain();
      or_force = 1'b1; or_val = 1'b1;
      repeat (3) @(posedge clk);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
